// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - decode-side inputs and ID/EX register outputs of the decode stage
interface decode_stage_if;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
    logic        StallE;
    logic        FlushE;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic        RegWriteE;
    logic        MemWriteE;
    logic        JumpE;
    logic        BranchE;
    logic        ALUSrcE;
    logic        ValidE;
    logic        IllegalE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E;
    logic [31:0] RD2E;
    logic [31:0] ImmExtE;
    logic [31:0] PCE;
    logic [31:0] PCPlus4E;
    logic [4:0]  Rs1E;
    logic [4:0]  Rs2E;
    logic [4:0]  RdE;

    modport slave (
        input  InstrD, PCD, PCPlus4D, ValidD, StallE, FlushE, RD1, RD2,
               RegWriteW, RdW, ResultW,
        output A1, A2, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ValidE,
               IllegalE, ResultSrcE, ALUControlE, RD1E, RD2E, ImmExtE, PCE,
               PCPlus4E, Rs1E, Rs2E, RdE
    );

    modport master (
        output InstrD, PCD, PCPlus4D, ValidD, StallE, FlushE, RD1, RD2,
               RegWriteW, RdW, ResultW,
        input  A1, A2, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ValidE,
               IllegalE, ResultSrcE, ALUControlE, RD1E, RD2E, ImmExtE, PCE,
               PCPlus4E, Rs1E, Rs2E, RdE
    );
endinterface

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32 subset instruction decode with W-port bypass and ID/EX register
module decode_stage (
    input  logic               clk,
    input  logic               rst,
    decode_stage_if.slave      bus
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        jump;
        logic        branch;
        logic        alu_src;
        logic        valid;
        logic        illegal;
        logic [1:0]  result_src;
        logic [2:0]  alu_ctl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } idex_t;

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        legal;
    logic        reg_write;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        alu_src;
    logic [1:0]  result_src;
    logic [2:0]  alu_ctl;
    logic [31:0] imm;
    idex_t       idex_d;
    idex_t       idex_q;

    assign instr  = bus.InstrD;
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    // LUI and JAL have no rs1; pinning A1 to x0 keeps stale bits out of the bypass compare
    assign a1     = (opcode == OP_LUI || opcode == OP_JAL) ? 5'd0 : instr[19:15];
    assign a2     = instr[24:20];
    assign bus.A1 = a1;
    assign bus.A2 = a2;

    // Operand select: x0 reads as zero, otherwise prefer the writeback value over the stale register file
    always_comb begin
        op1 = bus.RD1;
        op2 = bus.RD2;
        if (bus.RegWriteW && bus.RdW != 5'd0 && bus.RdW == a1) op1 = bus.ResultW;
        if (bus.RegWriteW && bus.RdW != 5'd0 && bus.RdW == a2) op2 = bus.ResultW;
        if (a1 == 5'd0) op1 = '0;
        if (a2 == 5'd0) op2 = '0;
    end

    // Control and immediate decode from opcode/funct3
    always_comb begin
        legal      = 1'b1;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        jump       = 1'b0;
        branch     = 1'b0;
        alu_src    = 1'b0;
        result_src = 2'b00;
        alu_ctl    = ALU_ADD;
        imm        = '0;
        case (opcode)
            OP_R, OP_I: begin
                reg_write = 1'b1;
                alu_src   = (opcode == OP_I);
                imm       = (opcode == OP_I) ? {{20{instr[31]}}, instr[31:20]} : 32'd0;
                case (funct3)
                    3'b000:  alu_ctl = (opcode == OP_R && instr[30]) ? ALU_SUB : ALU_ADD;
                    3'b111:  alu_ctl = ALU_AND;
                    3'b110:  alu_ctl = ALU_OR;
                    3'b010:  alu_ctl = ALU_SLT;
                    default: legal   = 1'b0;
                endcase
            end
            OP_LOAD: begin
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                result_src = 2'b01;
                imm        = {{20{instr[31]}}, instr[31:20]};
            end
            OP_STORE: begin
                mem_write = 1'b1;
                alu_src   = 1'b1;
                imm       = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OP_BRANCH: begin
                branch  = 1'b1;
                alu_ctl = ALU_SUB;
                imm     = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OP_JAL: begin
                jump       = 1'b1;
                reg_write  = 1'b1;
                result_src = 2'b10;
                imm        = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            OP_LUI: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                imm       = {instr[31:12], 12'b0};
            end
            default: legal = 1'b0;
        endcase
    end

    // Assemble the ID/EX payload; a bubble is all-zero, an illegal op keeps its datapath but no side effects
    always_comb begin
        idex_d = '0;
        if (bus.ValidD) begin
            idex_d.valid      = 1'b1;
            idex_d.illegal    = ~legal;
            idex_d.reg_write  = legal & reg_write;
            idex_d.mem_write  = legal & mem_write;
            idex_d.jump       = legal & jump;
            idex_d.branch     = legal & branch;
            idex_d.alu_src    = legal & alu_src;
            idex_d.result_src = legal ? result_src : 2'b00;
            idex_d.alu_ctl    = legal ? alu_ctl : ALU_ADD;
            idex_d.rd1        = op1;
            idex_d.rd2        = op2;
            idex_d.imm        = imm;
            idex_d.pc         = bus.PCD;
            idex_d.pc_plus4   = bus.PCPlus4D;
            idex_d.rs1        = a1;
            idex_d.rs2        = a2;
            idex_d.rd         = instr[11:7];
        end
    end

    // ID/EX register: reset and flush both win over stall, stall holds everything
    always_ff @(posedge clk) begin
        if (!rst || bus.FlushE) begin
            idex_q <= '0;
        end else if (!bus.StallE) begin
            idex_q <= idex_d;
        end
    end

    assign bus.RegWriteE   = idex_q.reg_write;
    assign bus.MemWriteE   = idex_q.mem_write;
    assign bus.JumpE       = idex_q.jump;
    assign bus.BranchE     = idex_q.branch;
    assign bus.ALUSrcE     = idex_q.alu_src;
    assign bus.ValidE      = idex_q.valid;
    assign bus.IllegalE    = idex_q.illegal;
    assign bus.ResultSrcE  = idex_q.result_src;
    assign bus.ALUControlE = idex_q.alu_ctl;
    assign bus.RD1E        = idex_q.rd1;
    assign bus.RD2E        = idex_q.rd2;
    assign bus.ImmExtE     = idex_q.imm;
    assign bus.PCE         = idex_q.pc;
    assign bus.PCPlus4E    = idex_q.pc_plus4;
    assign bus.Rs1E        = idex_q.rs1;
    assign bus.Rs2E        = idex_q.rs2;
    assign bus.RdE         = idex_q.rd;
endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage
module tb_decode_stage;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cmp_cnt = 0;
    int   err_cnt = 0;

    decode_stage_if dif();

    decode_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    always #5 clk = ~clk;

    logic [186:0] all_e;
    assign all_e = {dif.RegWriteE, dif.MemWriteE, dif.JumpE, dif.BranchE, dif.ALUSrcE,
                    dif.ValidE, dif.IllegalE, dif.ResultSrcE, dif.ALUControlE, dif.RD1E,
                    dif.RD2E, dif.ImmExtE, dif.PCE, dif.PCPlus4E, dif.Rs1E, dif.Rs2E, dif.RdE};

    task automatic drive(input logic [31:0] instr, input logic valid, input logic stall,
                         input logic flush, input logic [31:0] rd1, input logic [31:0] rd2,
                         input logic rw, input logic [4:0] rdw, input logic [31:0] resw,
                         input logic [31:0] pc);
        dif.InstrD    = instr;
        dif.ValidD    = valid;
        dif.StallE    = stall;
        dif.FlushE    = flush;
        dif.RD1       = rd1;
        dif.RD2       = rd2;
        dif.RegWriteW = rw;
        dif.RdW       = rdw;
        dif.ResultW   = resw;
        dif.PCD       = pc;
        dif.PCPlus4D  = pc + 32'd4;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(32'h00528093, 1'b1, 1'b0, 1'b0, 32'h11, 32'h22, 1'b0, 5'd0, 32'd0, 32'h100);
        #1;
        cmp_cnt++; if (dif.A1 !== 5'd5) begin err_cnt++; $display("FAIL reset_a1_comb got %0d want 5", dif.A1); end
        tick();
        cmp_cnt++; if (all_e !== '0) begin err_cnt++; $display("FAIL reset_all_e got %h want 0", all_e); end
        rst = 1'b1;
        drive(32'h00528093, 1'b0, 1'b0, 1'b0, 32'h11, 32'h22, 1'b0, 5'd0, 32'd0, 32'h104);
        tick();
        cmp_cnt++; if (all_e !== '0) begin err_cnt++; $display("FAIL reset_bubble_all_e got %h want 0", all_e); end
    endtask

    task automatic test_addi();
        drive(32'h00500093, 1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 1'b0, 5'd0, 32'd0, 32'h200);
        tick();
        cmp_cnt++; if ({dif.RegWriteE, dif.ALUSrcE, dif.ValidE, dif.IllegalE} !== 4'b1110) begin err_cnt++; $display("FAIL addi_ctl got %b want 1110", {dif.RegWriteE, dif.ALUSrcE, dif.ValidE, dif.IllegalE}); end
        cmp_cnt++; if (dif.ImmExtE !== 32'd5) begin err_cnt++; $display("FAIL addi_imm got %h want 5", dif.ImmExtE); end
        cmp_cnt++; if (dif.RdE !== 5'd1) begin err_cnt++; $display("FAIL addi_rd got %0d want 1", dif.RdE); end
        cmp_cnt++; if (dif.RD1E !== 32'd0) begin err_cnt++; $display("FAIL addi_rd1_x0 got %h want 0", dif.RD1E); end
        cmp_cnt++; if (dif.ALUControlE !== 3'b000) begin err_cnt++; $display("FAIL addi_alu got %b want 000", dif.ALUControlE); end
        cmp_cnt++; if ({dif.PCE, dif.PCPlus4E} !== {32'h200, 32'h204}) begin err_cnt++; $display("FAIL addi_pc got %h/%h want 200/204", dif.PCE, dif.PCPlus4E); end
    endtask

    task automatic test_sub_bypass();
        drive(32'h40208133, 1'b1, 1'b0, 1'b0, 32'd7, 32'd3, 1'b1, 5'd1, 32'd9, 32'h300);
        #1;
        cmp_cnt++; if ({dif.A1, dif.A2} !== {5'd1, 5'd2}) begin err_cnt++; $display("FAIL sub_addr got %0d/%0d want 1/2", dif.A1, dif.A2); end
        tick();
        cmp_cnt++; if (dif.RD1E !== 32'd9) begin err_cnt++; $display("FAIL sub_rd1_bypass got %h want 9", dif.RD1E); end
        cmp_cnt++; if (dif.RD2E !== 32'd3) begin err_cnt++; $display("FAIL sub_rd2 got %h want 3", dif.RD2E); end
        cmp_cnt++; if (dif.ALUControlE !== 3'b001) begin err_cnt++; $display("FAIL sub_alu got %b want 001", dif.ALUControlE); end
        cmp_cnt++; if ({dif.Rs1E, dif.Rs2E, dif.RdE} !== {5'd1, 5'd2, 5'd2}) begin err_cnt++; $display("FAIL sub_idx got %0d/%0d/%0d want 1/2/2", dif.Rs1E, dif.Rs2E, dif.RdE); end
    endtask

    task automatic test_branch_stall_flush();
        drive(32'hFE000EE3, 1'b1, 1'b0, 1'b0, 32'h5, 32'h6, 1'b0, 5'd0, 32'd0, 32'h400);
        tick();
        cmp_cnt++; if ({dif.BranchE, dif.RegWriteE, dif.ALUSrcE, dif.ALUControlE} !== 6'b100001) begin err_cnt++; $display("FAIL beq_ctl got %b want 100001", {dif.BranchE, dif.RegWriteE, dif.ALUSrcE, dif.ALUControlE}); end
        cmp_cnt++; if (dif.ImmExtE !== 32'hFFFFFFFC) begin err_cnt++; $display("FAIL beq_imm got %h want fffffffc", dif.ImmExtE); end
        // stalled: a different instruction and a matching W write must not disturb the E outputs
        drive(32'h00500093, 1'b1, 1'b1, 1'b0, 32'h5, 32'h6, 1'b1, 5'd1, 32'hABCD, 32'h404);
        tick();
        tick();
        cmp_cnt++; if ({dif.BranchE, dif.ValidE, dif.RegWriteE} !== 3'b110) begin err_cnt++; $display("FAIL stall_ctl got %b want 110", {dif.BranchE, dif.ValidE, dif.RegWriteE}); end
        cmp_cnt++; if ({dif.ImmExtE, dif.PCE, dif.RD1E} !== {32'hFFFFFFFC, 32'h400, 32'h0}) begin err_cnt++; $display("FAIL stall_data got %h/%h/%h want fffffffc/400/0", dif.ImmExtE, dif.PCE, dif.RD1E); end
        drive(32'h00500093, 1'b1, 1'b1, 1'b1, 32'h5, 32'h6, 1'b0, 5'd0, 32'd0, 32'h408);
        tick();
        cmp_cnt++; if (all_e !== '0) begin err_cnt++; $display("FAIL flush_stall_bubble got %h want 0", all_e); end
    endtask

    task automatic test_x0_bypass();
        drive(32'h000001B3, 1'b1, 1'b0, 1'b0, 32'h11111111, 32'h22222222, 1'b1, 5'd0, 32'hDEADBEEF, 32'h500);
        tick();
        cmp_cnt++; if ({dif.RD1E, dif.RD2E} !== 64'd0) begin err_cnt++; $display("FAIL x0_operands got %h/%h want 0/0", dif.RD1E, dif.RD2E); end
        cmp_cnt++; if ({dif.RdE, dif.RegWriteE, dif.ALUControlE} !== {5'd3, 1'b1, 3'b000}) begin err_cnt++; $display("FAIL x0_add_ctl got %0d/%b/%b want 3/1/000", dif.RdE, dif.RegWriteE, dif.ALUControlE); end
    endtask

    task automatic test_illegal();
        drive(32'h0000007F, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'd0, 32'h600);
        tick();
        cmp_cnt++; if ({dif.IllegalE, dif.ValidE, dif.RegWriteE, dif.MemWriteE, dif.BranchE, dif.JumpE} !== 6'b110000) begin err_cnt++; $display("FAIL illegal_opcode got %b want 110000", {dif.IllegalE, dif.ValidE, dif.RegWriteE, dif.MemWriteE, dif.BranchE, dif.JumpE}); end
        // R-type with funct3=001 is not in the supported set
        drive(32'h003110B3, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'd0, 32'h604);
        tick();
        cmp_cnt++; if ({dif.IllegalE, dif.ValidE, dif.RegWriteE} !== 3'b110) begin err_cnt++; $display("FAIL illegal_funct3 got %b want 110", {dif.IllegalE, dif.ValidE, dif.RegWriteE}); end
    endtask

    task automatic test_store_load();
        drive(32'hFE512C23, 1'b1, 1'b0, 1'b0, 32'h1000, 32'h77, 1'b0, 5'd0, 32'd0, 32'h700);
        tick();
        cmp_cnt++; if ({dif.MemWriteE, dif.RegWriteE, dif.ALUSrcE, dif.ALUControlE} !== 6'b101000) begin err_cnt++; $display("FAIL sw_ctl got %b want 101000", {dif.MemWriteE, dif.RegWriteE, dif.ALUSrcE, dif.ALUControlE}); end
        cmp_cnt++; if ({dif.ImmExtE, dif.RD1E, dif.RD2E} !== {32'hFFFFFFF8, 32'h1000, 32'h77}) begin err_cnt++; $display("FAIL sw_data got %h/%h/%h want fffffff8/1000/77", dif.ImmExtE, dif.RD1E, dif.RD2E); end
        drive(32'hFFC3A303, 1'b1, 1'b0, 1'b0, 32'h2000, 32'h0, 1'b0, 5'd0, 32'd0, 32'h704);
        tick();
        cmp_cnt++; if ({dif.RegWriteE, dif.ALUSrcE, dif.ResultSrcE, dif.MemWriteE} !== 5'b11010) begin err_cnt++; $display("FAIL lw_ctl got %b want 11010", {dif.RegWriteE, dif.ALUSrcE, dif.ResultSrcE, dif.MemWriteE}); end
        cmp_cnt++; if ({dif.ImmExtE, dif.RdE} !== {32'hFFFFFFFC, 5'd6}) begin err_cnt++; $display("FAIL lw_imm_rd got %h/%0d want fffffffc/6", dif.ImmExtE, dif.RdE); end
    endtask

    task automatic test_jal_lui();
        drive(32'h008000EF, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'd0, 32'h800);
        tick();
        cmp_cnt++; if ({dif.JumpE, dif.RegWriteE, dif.ResultSrcE} !== 4'b1110) begin err_cnt++; $display("FAIL jal_ctl got %b want 1110", {dif.JumpE, dif.RegWriteE, dif.ResultSrcE}); end
        cmp_cnt++; if ({dif.ImmExtE, dif.PCPlus4E, dif.RdE} !== {32'd8, 32'h804, 5'd1}) begin err_cnt++; $display("FAIL jal_data got %h/%h/%0d want 8/804/1", dif.ImmExtE, dif.PCPlus4E, dif.RdE); end
        drive(32'h123452B7, 1'b1, 1'b0, 1'b0, 32'hAAAA, 32'h0, 1'b1, 5'd8, 32'h5555, 32'h808);
        #1;
        cmp_cnt++; if (dif.A1 !== 5'd0) begin err_cnt++; $display("FAIL lui_a1_forced got %0d want 0", dif.A1); end
        tick();
        cmp_cnt++; if ({dif.ImmExtE, dif.RD1E, dif.Rs1E} !== {32'h12345000, 32'h0, 5'd0}) begin err_cnt++; $display("FAIL lui_data got %h/%h/%0d want 12345000/0/0", dif.ImmExtE, dif.RD1E, dif.Rs1E); end
        cmp_cnt++; if ({dif.RegWriteE, dif.ALUSrcE, dif.ResultSrcE, dif.ALUControlE} !== 7'b1100000) begin err_cnt++; $display("FAIL lui_ctl got %b want 1100000", {dif.RegWriteE, dif.ALUSrcE, dif.ResultSrcE, dif.ALUControlE}); end
    endtask

    task automatic test_bubble_midreset();
        drive(32'h00500093, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'd0, 32'h900);
        tick();
        cmp_cnt++; if (dif.ValidE !== 1'b1) begin err_cnt++; $display("FAIL pre_bubble_valid got %b want 1", dif.ValidE); end
        drive(32'h00500093, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'd0, 32'h904);
        tick();
        cmp_cnt++; if (all_e !== '0) begin err_cnt++; $display("FAIL validd0_bubble got %h want 0", all_e); end
        drive(32'h40208133, 1'b1, 1'b0, 1'b0, 32'd7, 32'd3, 1'b0, 5'd0, 32'd0, 32'h908);
        tick();
        cmp_cnt++; if (dif.ALUControlE !== 3'b001) begin err_cnt++; $display("FAIL pre_reset_sub got %b want 001", dif.ALUControlE); end
        rst = 1'b0;
        drive(32'hFE000EE3, 1'b1, 1'b1, 1'b0, 32'd7, 32'd3, 1'b0, 5'd0, 32'd0, 32'h90C);
        tick();
        cmp_cnt++; if (all_e !== '0) begin err_cnt++; $display("FAIL midreset_bubble got %h want 0", all_e); end
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_sub_bypass();
        test_branch_stall_flush();
        test_x0_bypass();
        test_illegal();
        test_store_load();
        test_jal_lui();
        test_bubble_midreset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
